jk_counter_ctrl: RTL and testbench

- Programmable up/down counter built from a bank of W single-edge JK flip-flop cells.
- The controller sequences the bank with a start/done handshake: it computes per-bit J/K each cycle to hold, load, count up, count down or reload.
- Sits above the JK cell primitives and is used wherever a terminal-count event generator is needed.

---
 rtl/jk_counter_ctrl_pkg.sv | 21 ++
 rtl/jk_counter_ctrl_cell.sv | 22 ++
 rtl/jk_counter_ctrl.sv | 116 +++++++++++
 tb/tb_jk_counter_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/jk_counter_ctrl_pkg.sv
// jk_counter_ctrl_pkg: shared FSM state codes and JK drive codes
package jk_counter_ctrl_pkg;

   typedef logic [1:0] state_t;
   typedef logic [1:0] jk_code_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_LOAD = 2'd1;
   localparam state_t ST_RUN  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   localparam jk_code_t JK_HOLD   = 2'd0;
   localparam jk_code_t JK_LOAD   = 2'd1;
   localparam jk_code_t JK_TOGGLE = 2'd2;

   // Turns a drive code plus the bit to load into the {J,K} pair of one cell.
   function automatic logic [1:0] jk_drive(input jk_code_t code, input logic b);
      return (code == JK_TOGGLE) ? 2'b11 : (code == JK_LOAD) ? {b, ~b} : 2'b00;
   endfunction

endpackage

// File: rtl/jk_counter_ctrl_cell.sv
// jk_cell: single posedge JK flip-flop with synchronous active-high reset
module jk_cell (
   input  logic clk,
   input  logic rst,
   input  logic j_i,
   input  logic k_i,
   output logic q_o,
   output logic qb_o
);

   logic q_q;

   // JK truth table: 00 hold, 01 clear, 10 set, 11 toggle.
   always_ff @(posedge clk) begin
      if (rst) q_q <= 1'b0;
      else     q_q <= (j_i & k_i) ? ~q_q : j_i ? 1'b1 : k_i ? 1'b0 : q_q;
   end

   assign q_o  = q_q;
   assign qb_o = ~q_q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// jk_counter_ctrl: start/done sequencer driving a bank of JK cells as a programmable counter
module jk_counter_ctrl
   import jk_counter_ctrl_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic         hold,
   input  logic         up_dn,
   input  logic         mode_wrap,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] term_val,
   output logic [W-1:0] count,
   output logic         busy,
   output logic         done
);

   state_t         state_q, state_d;
   logic [W-1:0]   load_cfg_q, term_cfg_q;
   logic           up_cfg_q, wrap_cfg_q;
   logic           done_q, done_d;
   logic           bank_load, bank_count;
   logic [W-1:0]   j, k, q, qb;
   logic           all1, all0, tog;
   jk_code_t       code;

   // Next-state and bank action; abort beats hold beats the terminal check.
   always_comb begin
      state_d    = state_q;
      done_d     = 1'b0;
      bank_load  = 1'b0;
      bank_count = 1'b0;
      case (state_q)
         ST_IDLE: state_d = start ? ST_LOAD : ST_IDLE;
         ST_LOAD: begin
            state_d   = abort ? ST_IDLE : ST_RUN;
            bank_load = ~abort;
         end
         ST_RUN: begin
            if (abort) state_d = ST_IDLE;
            else if (!hold) begin
               if (q == term_cfg_q) begin
                  done_d    = 1'b1;
                  bank_load = wrap_cfg_q;
                  state_d   = wrap_cfg_q ? ST_RUN : ST_DONE;
               end else begin
                  bank_count = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Per-bit J/K: a bit toggles when all lower bits are ones (up) or zeros (down, via qb).
   always_comb begin
      all1 = 1'b1;
      all0 = 1'b1;
      tog  = 1'b0;
      code = JK_HOLD;
      j    = '0;
      k    = '0;
      for (int i = 0; i < W; i++) begin
         tog  = up_cfg_q ? all1 : all0;
         code = bank_load ? JK_LOAD : (bank_count && tog) ? JK_TOGGLE : JK_HOLD;
         {j[i], k[i]} = jk_drive(code, load_cfg_q[i]);
         all1 = all1 & q[i];
         all0 = all0 & qb[i];
      end
   end

   // State and registered done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // Run configuration is captured only by a start accepted in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         load_cfg_q <= '0;
         term_cfg_q <= '0;
         up_cfg_q   <= 1'b0;
         wrap_cfg_q <= 1'b0;
      end else if (state_q == ST_IDLE && start) begin
         load_cfg_q <= load_val;
         term_cfg_q <= term_val;
         up_cfg_q   <= up_dn;
         wrap_cfg_q <= mode_wrap;
      end
   end

   for (genvar g = 0; g < W; g++) begin : g_cell
      jk_cell u_cell (
         .clk  (clk),
         .rst  (rst),
         .j_i  (j[g]),
         .k_i  (k[g]),
         .q_o  (q[g]),
         .qb_o (qb[g])
      );
   end

   assign count = q;
   assign busy  = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign done  = done_q;

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// tb_jk_counter_ctrl: table-driven scoreboard bench for jk_counter_ctrl
module tb_jk_counter_ctrl;

   typedef struct {
      logic       r, s, a, h, u, w;
      logic [3:0] l, t;
      logic [3:0] c;
      logic       b, d;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, start, abort, hold, up_dn, mode_wrap;
   logic [3:0] load_val, term_val, count;
   logic       busy, done;

   vec_t       vecs[$];
   logic [5:0] exp_q[$];
   int         n_chk = 0;
   int         n_fail = 0;

   jk_counter_ctrl #(.W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
      .up_dn(up_dn), .mode_wrap(mode_wrap), .load_val(load_val), .term_val(term_val),
      .count(count), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, s, a, h, u, w, input logic [3:0] l, t, c,
                               input logic b, d);
      vec_t v;
      v.r = r; v.s = s; v.a = a; v.h = h; v.u = u; v.w = w;
      v.l = l; v.t = t; v.c = c; v.b = b; v.d = d;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst = v.r; start = v.s; abort = v.a; hold = v.h;
      up_dn = v.u; mode_wrap = v.w; load_val = v.l; term_val = v.t;
   endtask

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got count=%0d busy=%0b done=%0b, expected count=%0d busy=%0b done=%0b",
                  name, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic [5:0] e;
      // reset
      vecs.push_back(mk(1,0,0,0,0,0, 0, 0,  0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 0, 0,  0,0,0));
      // up, stop: load 3 term 6
      vecs.push_back(mk(0,1,0,0,1,0, 3, 6,  0,1,0));
      vecs.push_back(mk(0,0,0,0,0,1, 9, 9,  3,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  4,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  5,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  6,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  6,0,1));
      vecs.push_back(mk(0,1,0,0,0,0, 9, 9,  6,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  6,0,0));
      // reset mid-count
      vecs.push_back(mk(0,1,0,0,1,0,10,15,  6,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 10,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 11,1,0));
      vecs.push_back(mk(1,0,0,0,0,0, 0, 0,  0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 0, 0,  0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  0,0,0));
      // down, wrap: load 2 term 0
      vecs.push_back(mk(0,1,0,0,0,1, 2, 0,  0,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  2,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  1,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  0,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  2,1,1));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  1,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  0,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  2,1,1));
      vecs.push_back(mk(0,0,1,0,0,0, 0, 0,  2,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  2,0,0));
      // modulo wrap: load 14 term 1 up
      vecs.push_back(mk(0,1,0,0,1,0,14, 1,  2,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 14,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 15,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  0,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  1,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  1,0,1));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  1,0,0));
      // hold at terminal count
      vecs.push_back(mk(0,1,0,0,1,0, 3, 5,  1,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  3,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  4,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  5,1,0));
      vecs.push_back(mk(0,0,0,1,0,0, 0, 0,  5,1,0));
      vecs.push_back(mk(0,0,0,1,0,0, 0, 0,  5,1,0));
      vecs.push_back(mk(0,0,0,1,0,0, 0, 0,  5,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  5,0,1));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  5,0,0));
      // start while busy ignored, then abort in RUN
      vecs.push_back(mk(0,1,0,0,1,0, 0, 9,  5,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  0,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  1,1,0));
      vecs.push_back(mk(0,1,0,0,0,1, 7, 2,  2,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  3,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  4,1,0));
      vecs.push_back(mk(0,0,1,0,0,0, 0, 0,  4,0,0));
      // abort in LOAD: no load
      vecs.push_back(mk(0,1,0,0,1,0, 8, 9,  4,1,0));
      vecs.push_back(mk(0,0,1,0,0,0, 0, 0,  4,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  4,0,0));
      // load == term, wrap: done every RUN cycle
      vecs.push_back(mk(0,1,0,0,1,1, 7, 7,  4,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  7,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  7,1,1));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  7,1,1));
      vecs.push_back(mk(0,0,1,0,0,0, 0, 0,  7,0,0));
      // load == term, stop
      vecs.push_back(mk(0,1,0,0,1,0, 7, 7,  7,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  7,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  7,0,1));
      vecs.push_back(mk(0,0,0,0,0,0, 0, 0,  7,0,0));

      drive(vecs[0]);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         exp_q.push_back({vecs[i].c, vecs[i].b, vecs[i].d});
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check($sformatf("vec%0d", i), {count, busy, done}, e);
      end

      // latency from accepted start to done: LOAD, 3 count edges, match edge
      @(negedge clk);
      drive(mk(0,1,0,0,1,0, 0, 3,  0,0,0));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", {n[3:0], 2'b01}, {4'd5, busy, done});
      check("term_state", {count, busy, done}, {4'd3, 1'b0, 1'b1});
      @(posedge clk);
      #1;
      check("pulse_width", {count, busy, done}, {4'd3, 1'b0, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
